// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC sequencer: FSM state encoding and the
// fixed fetch-address map (reset base, exception entry, legal text window).
// Imported by npc_sequencer and npc_range_chk.
package npc_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } npc_state_e;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO   = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI   = 32'h0000_6ffc;

    // Sequential successor; wraps modulo 2^32 and the wrap is caught by the range check
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/npc_range_chk.sv
// Purpose: flags a fetch address that is misaligned or outside the text window.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle on whatever address is presented.
module npc_range_chk
    import npc_pkg::*;
(
    input  logic [31:0] addr_i,
    output logic        fetch_exc_o
);

    // Word alignment plus inclusive [TEXT_LO, TEXT_HI] window, all unsigned
    always_comb begin
        fetch_exc_o = (addr_i[1:0] != 2'b00) || (addr_i < TEXT_LO) || (addr_i > TEXT_HI);
    end

endmodule

// File: rtl/npc_sequencer.sv
// Purpose: selects the next fetch PC (exception > ERET > held redirect > redirect > PC+4),
//          holds redirects decided under stall, flushes F/D after exception/ERET, tracks BD.
// Latency: next_pc/pc_en/pc_req/fetch_exc combinational; flush_fd and d_bd registered.
// Backpressure: stall freezes the PC except for exception entry and ERET, which always act.
// Optional: define NPC_PERF_CNT_EN to add perf_redirects / perf_stall_cycles counters.
module npc_sequencer
    import npc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] f_pc,
    input  logic        stall,
    input  logic        d_redirect,
    input  logic [31:0] d_target,
    input  logic        d_is_cti,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] next_pc,
    output logic        pc_en,
    output logic        pc_req,
    output logic        flush_fd,
    output logic        d_bd,
`ifdef NPC_PERF_CNT_EN
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_stall_cycles,
`endif
    output logic        fetch_exc
);

    npc_state_e  state_q, state_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        d_bd_q, d_bd_d;
    logic        redirect_applied;

    // Next-PC source selection and FSM next-state; outputs are forced quiet during reset
    always_comb begin
        state_d          = state_q;
        pend_target_d    = pend_target_q;
        next_pc          = seq_pc(f_pc);
        pc_en            = 1'b0;
        pc_req           = 1'b0;
        redirect_applied = 1'b0;

        if (reset) begin
            next_pc = RESET_PC;
        end else if (exc_req) begin
            // Exception entry overrides everything, including stall and a held redirect
            next_pc = EXC_ENTRY;
            pc_en   = 1'b1;
            pc_req  = 1'b1;
            state_d = FLUSH;
        end else if (eret && (state_q != FLUSH)) begin
            next_pc = epc;
            pc_en   = 1'b1;
            state_d = FLUSH;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (d_redirect) begin
                        if (!stall) begin
                            // Delay slot is already in F, so the target is fetched next
                            next_pc          = d_target;
                            pc_en            = 1'b1;
                            redirect_applied = 1'b1;
                        end else begin
                            // First assertion under stall is latched; later targets ignored
                            pend_target_d = d_target;
                            state_d       = PEND;
                        end
                    end else begin
                        pc_en = !stall;
                    end
                end
                PEND: begin
                    next_pc = pend_target_q;
                    if (!stall) begin
                        pc_en            = 1'b1;
                        redirect_applied = 1'b1;
                        state_d          = RUN;
                    end
                end
                FLUSH: begin
                    // Whatever sits in D is being squashed, so its redirect/ERET is stale
                    pc_en   = !stall;
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign flush_fd = (state_q == FLUSH);

    // Delay-slot flag follows the F/D register: cleared on exception entry or flush
    always_comb begin
        d_bd_d = d_bd_q;
        if (pc_req || flush_fd) begin
            d_bd_d = 1'b0;
        end else if (pc_en) begin
            d_bd_d = d_is_cti && (state_q != FLUSH);
        end
    end

    assign d_bd = d_bd_q;

    // FSM state, held redirect target and BD flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pend_target_q <= 32'd0;
            d_bd_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
            d_bd_q        <= d_bd_d;
        end
    end

`ifdef NPC_PERF_CNT_EN
    logic [31:0] perf_redirects_q;
    logic [31:0] perf_stall_cycles_q;

    // Free-running wrap-around event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_redirects_q    <= 32'd0;
            perf_stall_cycles_q <= 32'd0;
        end else begin
            if (redirect_applied) begin
                perf_redirects_q <= perf_redirects_q + 32'd1;
            end
            if (stall && !exc_req && !eret) begin
                perf_stall_cycles_q <= perf_stall_cycles_q + 32'd1;
            end
        end
    end

    assign perf_redirects    = perf_redirects_q;
    assign perf_stall_cycles = perf_stall_cycles_q;
`else
    // Applied-redirect strobe only feeds the optional counters
    logic unused_redirect_applied;
    assign unused_redirect_applied = redirect_applied;
`endif

    npc_range_chk u_range_chk (
        .addr_i      (next_pc),
        .fetch_exc_o (fetch_exc)
    );

endmodule
